// File: rtl/inst_mem_resp_pkg.sv
// Shared constants, types and LFSR step for the instruction-fetch responder.
package inst_mem_resp_pkg;

    localparam int unsigned INST_W      = 32;
    localparam int unsigned BYTE_ADDR_W = 32;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } resp_err_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam int unsigned     LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        resp_err_e         err;
    } pipe_entry_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/inst_mem_resp_if.sv
// Fetch request/response and store-load bundle between fetch stage and responder.
interface inst_mem_resp_if
    import inst_mem_resp_pkg::*;
#(
    parameter int unsigned LOAD_AW = 10
);

    logic                   req_valid;
    logic [BYTE_ADDR_W-1:0] req_addr;
    logic                   req_ready;
    logic                   flush;
    logic                   resp_valid;
    logic [INST_W-1:0]      resp_inst;
    logic                   resp_err;
    logic                   load_en;
    logic [LOAD_AW-1:0]     load_addr;
    logic [INST_W-1:0]      load_data;

    modport master (
        output req_valid, req_addr, flush, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/inst_mem_pipe.sv
// LATENCY-deep in-flight response shift register; flush clears every stage synchronously.
module inst_mem_pipe
    import inst_mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  pipe_entry_t head,
    output pipe_entry_t tail
);

    pipe_entry_t stage [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= head;
            for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign tail = stage[LATENCY-1];

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: store, address check, handshake, fixed-latency response.
// Optional INST_MEM_STALL_INJECT_EN adds LFSR-driven pseudo-random req_ready stalls.
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int unsigned            DEPTH_WORDS = 1024,
    parameter int unsigned            LATENCY     = 1,
    parameter logic [BYTE_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    inst_mem_resp_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [INST_W-1:0]      store [DEPTH_WORDS];
    logic [BYTE_ADDR_W-1:0] offset;
    logic [AW-1:0]          word_idx;
    logic                   addr_ok;
    logic                   ready_q;
    logic                   stall;
    logic                   accept;
    pipe_entry_t            cap;
    pipe_entry_t            tail;

    // Underflow of the subtraction is caught by the explicit lower-bound compare.
    always_comb begin
        offset   = bus.req_addr - BASE_ADDR;
        word_idx = offset[AW+1:2];
        addr_ok  = (bus.req_addr[1:0] == 2'b00)
                && (bus.req_addr >= BASE_ADDR)
                && ((offset >> 2) < DEPTH_WORDS);
    end

`ifdef INST_MEM_STALL_INJECT_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_step(lfsr);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= !bus.load_en;
    end

    assign bus.req_ready = ready_q && !stall;
    assign accept        = bus.req_valid && bus.req_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (bus.load_en) store[bus.load_addr] <= bus.load_data;
    end

    // Capture register samples the store at the accept edge; the pipe then adds
    // LATENCY more stages so the response appears LATENCY edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= '0;
        end else begin
            cap.valid <= accept;
            cap.inst  <= (accept && addr_ok) ? store[word_idx] : '0;
            cap.err   <= (accept && !addr_ok) ? RESP_ERR : RESP_OK;
        end
    end

    inst_mem_pipe #(
        .LATENCY(LATENCY)
    ) u_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(bus.flush),
        .head (cap),
        .tail (tail)
    );

    assign bus.resp_valid = tail.valid;
    assign bus.resp_inst  = tail.inst;
    assign bus.resp_err   = tail.err;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: LATENCY=2 and LATENCY=3 instances share one stimulus.
module tb_inst_mem_resp;

    localparam int unsigned DW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    inst_mem_resp_if #(.LOAD_AW(4)) if2 ();
    inst_mem_resp_if #(.LOAD_AW(4)) if3 ();

    assign if2.req_valid = req_valid;  assign if3.req_valid = req_valid;
    assign if2.req_addr  = req_addr;   assign if3.req_addr  = req_addr;
    assign if2.flush     = flush;      assign if3.flush     = flush;
    assign if2.load_en   = load_en;    assign if3.load_en   = load_en;
    assign if2.load_addr = load_addr;  assign if3.load_addr = load_addr;
    assign if2.load_data = load_data;  assign if3.load_data = load_data;

    inst_mem_resp #(.DEPTH_WORDS(DW), .LATENCY(2), .BASE_ADDR(BASE)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    inst_mem_resp #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(BASE)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic [1:0]  rv, rr, re;
    logic [31:0] ri [2];
    assign rv[0] = if2.resp_valid; assign rv[1] = if3.resp_valid;
    assign rr[0] = if2.req_ready;  assign rr[1] = if3.req_ready;
    assign re[0] = if2.resp_err;   assign re[1] = if3.resp_err;
    assign ri[0] = if2.resp_inst;  assign ri[1] = if3.resp_inst;

    typedef struct {
        int unsigned due;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned cyc;
    int          n_chk;
    int          n_pass;

    logic [31:0] mem_m [DW];
    logic [15:0] lfsr_m;
    logic        base_rdy;
    logic        exp_rdy;
    logic        cur_rdy;
    logic        a_ok;
    int unsigned a_word;
    exp_t        p_e;
    exp_t        m_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic stall_free(input logic [15:0] s);
`ifdef INST_MEM_STALL_INJECT_EN
        return s[1:0] != 2'b00;
`else
        return (s == s);
`endif
    endfunction

    function automatic int qsize(input int k);
        if (k == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic int unsigned qdue(input int k);
        if (k == 0) return q0[0].due;
        return q1[0].due;
    endfunction

    task automatic qpop(input int k, output exp_t e);
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic chk(input bit ok, input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s (LATENCY=%0d) cycle %0d: got %h, expected %h",
                      name, k + 2, cyc, act, exp);
    endtask

    // Expectation side: sees stable inputs just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            base_rdy = 1'b0;
            exp_rdy  = 1'b0;
            lfsr_m   = 16'hACE1;
        end else begin
            cur_rdy = exp_rdy;
            if (flush) begin
                q0.delete();
                q1.delete();
            end
            if (req_valid && cur_rdy && !flush) begin
                a_word = (req_addr - BASE) >> 2;
                a_ok   = (req_addr[1:0] == 2'b00) && (req_addr >= BASE) && (a_word < DW);
                p_e.inst = a_ok ? mem_m[a_word[3:0]] : 32'h0;
                p_e.err  = !a_ok;
                p_e.due  = cyc + 3;
                q0.push_back(p_e);
                p_e.due  = cyc + 4;
                q1.push_back(p_e);
            end
            if (load_en) mem_m[load_addr] = load_data;
            base_rdy = !load_en;
            lfsr_m   = model_lfsr(lfsr_m);
            exp_rdy  = base_rdy && stall_free(lfsr_m);
        end
    end

    // Monitor: compares both DUTs against their queues at every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk(rv[k] === 1'b0, "rst_resp_valid", k, 32'(rv[k]), 32'h0);
                chk(rr[k] === 1'b0, "rst_req_ready", k, 32'(rr[k]), 32'h0);
                chk(ri[k] === 32'h0 && re[k] === 1'b0, "rst_resp_data", k, ri[k], 32'h0);
            end else begin
                chk(rr[k] === exp_rdy, "req_ready", k, 32'(rr[k]), 32'(exp_rdy));
                if (qsize(k) != 0 && qdue(k) <= cyc) begin
                    qpop(k, m_e);
                    chk(rv[k] === 1'b1, "resp_valid", k, 32'(rv[k]), 32'h1);
                    if (rv[k] === 1'b1) begin
                        chk(ri[k] === m_e.inst, "resp_inst", k, ri[k], m_e.inst);
                        chk(re[k] === m_e.err, "resp_err", k, 32'(re[k]), 32'(m_e.err));
                    end
                end else begin
                    chk(rv[k] === 1'b0, "spurious_valid", k, 32'(rv[k]), 32'h0);
                    chk(ri[k] === 32'h0 && re[k] === 1'b0, "idle_zero", k, ri[k], 32'h0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        flush     = 1'b0;
        load_en   = 1'b0;
        repeat (n) step();
    endtask

    task automatic req(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = (i < 4) ? 32'(32'h1111_1111 * (i + 1)) : (32'hA5A5_0000 | 32'(i));
            step();
        end
        idle(2);

        // In-order back-to-back fetches
        for (int i = 0; i < 4; i++) req(32'(i * 4));
        idle(6);

        // Misaligned, one-past-end, last word, wrap-around address
        req(32'h0000_0002);
        req(32'(DW * 4));
        req(32'(DW * 4 - 4));
        req(32'hFFFF_FFFC);
        idle(6);

        // Flush one cycle after the second accept; same-cycle request dropped
        req(32'h0);
        req(32'h4);
        flush = 1'b1;
        req(32'h8);
        flush = 1'b0;
        req(32'h8);
        idle(6);

        // Load then read back after the forced not-ready cycle
        load_en = 1'b1; load_addr = 4'd5; load_data = 32'hDEAD_BEEF; req_valid = 1'b0;
        step();
        load_en = 1'b0;
        req(32'd20);
        req(32'd20);
        idle(6);

        // Load on the same edge as an accepted read of that word
        load_en = 1'b1; load_addr = 4'd6; load_data = 32'hCAFE_F00D;
        req(32'd24);
        load_en = 1'b0;
        req(32'd24);
        req(32'd24);
        idle(6);

        // Asynchronous reset mid-cycle with requests in flight
        req(32'h0);
        req(32'h4);
        req(32'h8);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle(6);

        // Sustained request stream
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'((i % 8) * 4);
            step();
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Responder end of the instruction-fetch interface. The PC/fetch stage issues word addresses; this block returns the 32-bit instruction after a fixed, parameterised latency.
- It holds the instruction store, a LATENCY-deep in-flight pipeline, flush handling for branch redirects, and a load port used by the bench or boot logic.
- It sits between the fetch stage and the instruction memory array.

Parameters:
- DEPTH_WORDS, 1024: instruction store depth in 32-bit words; must be a power of 2.
- LATENCY, 1: cycles from request acceptance to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of the instruction.
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  branch redirect; discard all in-flight responses.
- resp_valid  out  1  response present; one-cycle pulse per accepted request.
- resp_inst  out  32  instruction word.
- resp_err  out  1  request was misaligned or out of range.
- load_en  in  1  write one word into the store.
- load_addr  in  log2(DEPTH_WORDS)  word index for the load.
- load_data  in  32  word to write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all in-flight pipeline valid bits clear;
  - resp_valid=0, resp_inst=0, resp_err=0, req_ready=0.
  - Store contents are not reset.
- First cycle after reset release: req_ready rises to 1, registered.
- Accept condition: req_valid && req_ready. No backpressure on the response side; the consumer always takes resp_valid.
- req_ready is 0 in the cycle after a load_en cycle, so a load is never read back on the same edge. It is also 0 during reset.
- Latency: a request accepted at edge N drives resp_valid=1 after edge N+LATENCY. Back-to-back accepts produce back-to-back responses, in order, throughput 1 per cycle.
- Address check, evaluated at accept:
  - misaligned (req_addr[1:0]!=0) -> resp_err=1, resp_inst=0;
  - out of range (addr<BASE_ADDR or word index>=DEPTH_WORDS) -> resp_err=1, resp_inst=0;
  - otherwise resp_err=0 and resp_inst = store[(req_addr-BASE_ADDR)>>2].
- Address arithmetic is 32-bit unsigned. Subtraction underflow counts as out of range.
- Read data is sampled at the accept edge. A load to the same word in a later cycle does not alter an accepted request.
- Flush:
  - clears every in-flight valid bit at the next edge, so no response from a request accepted before or at the flush edge is delivered;
  - a request presented in the same cycle as flush is dropped;
  - req_ready stays 1 during flush.
- Load while requests are in flight is legal; in-flight data is unaffected.
- Reset mid-flight discards everything; no response is ever produced for pre-reset requests.
- With no accepts, resp_valid=0 and resp_inst/resp_err hold 0.

Optional Feature:
- Macro: INST_MEM_STALL_INJECT_EN.
- Defined:
  - a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle;
  - req_ready is additionally forced 0 when LFSR[1:0]==2'b00, giving deterministic pseudo-random stalls for fetch-stage verification.
- Undefined: no LFSR logic; req_ready follows only the base rules.

Decomposition:
- Shared package holds:
  - instruction word width (32) and byte-address width constant;
  - resp error encoding constant;
  - LFSR seed/taps constants.
- One natural sub-module, inst_mem_pipe: LATENCY-deep valid/data/err shift register with synchronous clear on flush. The top holds the store, address check and handshake.

Test Plan:
- Reset then load words 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; request 0,4,8,12 back-to-back with LATENCY=2 -> resp_valid high 4 consecutive cycles starting 2 cycles after first accept, data in order, resp_err=0.
- Request 32'h0000_0002 -> resp_inst=0, resp_err=1 after LATENCY cycles; request DEPTH_WORDS*4 -> resp_err=1.
- Issue requests at 0,4, assert flush the cycle after the second accept, with LATENCY=3 -> zero responses delivered; request at 8 after flush returns store[2] normally.
- Load word 5 = 32'hDEADBEEF, then next cycle req_ready=0; the following cycle request 20 -> resp_inst=32'hDEADBEEF.
- Drop rst_n asynchronously mid-cycle with 2 requests in flight -> resp_valid falls immediately, no response after release; req_ready returns 1 one cycle after release.
- With INST_MEM_STALL_INJECT_EN, hold req_valid 64 cycles -> accepted count equals 64 minus the cycles where the LFSR model gives LFSR[1:0]==0, and responses match address order.
